// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM write path: bus widths, w_din field
// offsets and the writer state encoding also used by the arbiter.
package sram_pkg;

    localparam int ADDR_WIDTH = 19;
    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = 4;
    localparam int PIX_WIDTH  = 8;

    // w_din = {mask, addr, data}, data in the low bits
    localparam int W_DATA_LSB = 0;
    localparam int W_ADDR_LSB = DATA_WIDTH;

    function automatic int w_mask_lsb(input int addr_width);
        return DATA_WIDTH + addr_width;
    endfunction

    function automatic int w_din_width(input int addr_width);
        return MASK_WIDTH + addr_width + DATA_WIDTH;
    endfunction

    // Writer frame state
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Byte-enable mask covering lanes 0..last_lane
    function automatic logic [MASK_WIDTH-1:0] lane_mask(input logic [1:0] last_lane);
        logic [MASK_WIDTH-1:0] m;
        case (last_lane)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_pixel_packer.sv
// 4:1 pixel accumulator. Packs 8-bit pixels into a 32-bit word, lane 0 in
// the low byte, and produces the byte mask of the filled lanes. The packed
// word is presented combinationally in the cycle the closing pixel is taken
// so the parent can register it straight into its output stage.
module sram_pixel_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_take,
    input  logic        pix_restart,
    input  logic        pix_last,
    input  logic [7:0]  pix_data,
    output logic        word_emit,
    output logic [31:0] word_data,
    output logic [3:0]  word_mask
);
    import sram_pkg::*;

    logic [1:0]  fill_cnt;
    logic [23:0] acc_data;
    logic [1:0]  lane;
    logic [31:0] base_data;

    // Place the incoming pixel in its lane; a restart ignores any partial word
    always_comb begin
        lane      = pix_restart ? 2'd0 : fill_cnt;
        base_data = pix_restart ? 32'h0 : {8'h00, acc_data};
        word_data = base_data | ({24'h0, pix_data} << {lane, 3'b000});
        word_mask = lane_mask(lane);
        word_emit = pix_take && ((lane == 2'd3) || pix_last);
    end

    // Accumulate lanes; an emitted word leaves the accumulator empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_cnt <= 2'd0;
            acc_data <= 24'h0;
        end else if (pix_take) begin
            if (word_emit) begin
                fill_cnt <= 2'd0;
                acc_data <= 24'h0;
            end else begin
                fill_cnt <= lane + 2'd1;
                acc_data <= word_data[23:0];
            end
        end
    end

endmodule

// File: rtl/sram_pixel_writer.sv
// Pixel stream to SRAM arbiter write port. Packs grayscale pixels four per
// word, tracks the frame word address, and reports frame completion and
// overrun. Optional ping-pong buffering is enabled by defining the macro
// SRAM_WRITER_DOUBLE_BUFFER_EN.
module sram_pixel_writer #(
    parameter int ADDR_WIDTH  = sram_pkg::ADDR_WIDTH,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = 19200
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [7:0]                pix_data,
    input  logic                      pix_sof,
    input  logic                      pix_eof,
    output logic                      w_din_valid,
    input  logic                      w_din_ready,
    output logic [36+ADDR_WIDTH-1:0]  w_din,
    output logic                      frame_done,
    output logic [7:0]                frame_count,
    output logic                      overrun,
    output logic                      buf_sel
);
    import sram_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] BASE0    = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_WORDS - 1);

    logic [0:0]            state;
    logic                  eof_seen;
    logic                  w_eof;
    logic [ADDR_WIDTH-1:0] wd_idx;

    logic                  pix_acc;
    logic                  out_hs;
    logic                  eof_hs;
    logic                  in_frame;
    logic                  take;
    logic                  restart;
    logic                  emit;
    logic [31:0]           word_data;
    logic [3:0]            word_mask;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic                  wrap;
    logic [ADDR_WIDTH-1:0] word_base;
    logic [ADDR_WIDTH-1:0] word_addr;

    // Handshakes and frame qualification; pixels after eof or outside a
    // frame are dropped unless they start a new one
    always_comb begin
        pix_ready = !w_din_valid || w_din_ready;
        pix_acc   = pix_valid && pix_ready;
        out_hs    = w_din_valid && w_din_ready;
        eof_hs    = out_hs && w_eof;
        in_frame  = (state == ST_ACTIVE) && !eof_seen;
        restart   = pix_acc && pix_sof;
        take      = pix_acc && (pix_sof || in_frame);
        cur_idx   = restart ? '0 : wd_idx;
        wrap      = (cur_idx == LAST_IDX);
        next_idx  = wrap ? '0 : cur_idx + ADDR_WIDTH'(1);
        word_addr = word_base + cur_idx;
    end

`ifdef SRAM_WRITER_DOUBLE_BUFFER_EN
    localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(FRAME_BASE + FRAME_WORDS);

    logic frame_buf;
    logic next_buf;
    logic cur_buf;

    // A frame starting in the same cycle its predecessor completes already
    // belongs to the other buffer
    always_comb begin
        next_buf  = buf_sel ^ eof_hs;
        cur_buf   = restart ? next_buf : frame_buf;
        word_base = cur_buf ? BASE1 : BASE0;
    end

    // Buffer toggles on every completed frame; the frame latches its buffer at sof
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_sel   <= 1'b0;
            frame_buf <= 1'b0;
        end else begin
            if (eof_hs)
                buf_sel <= ~buf_sel;
            if (restart)
                frame_buf <= next_buf;
        end
    end
`else
    assign word_base = BASE0;
    assign buf_sel   = 1'b0;
`endif

    sram_pixel_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .pix_take    (take),
        .pix_restart (restart),
        .pix_last    (pix_eof),
        .pix_data    (pix_data),
        .word_emit   (emit),
        .word_data   (word_data),
        .word_mask   (word_mask)
    );

    // One-word output register toward the arbiter, held while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_din_valid <= 1'b0;
            w_din       <= '0;
            w_eof       <= 1'b0;
        end else if (emit) begin
            w_din_valid <= 1'b1;
            w_din       <= {word_mask, word_addr, word_data};
            w_eof       <= pix_eof;
        end else if (out_hs) begin
            w_din_valid <= 1'b0;
        end
    end

    // Word index within the frame; wrapping without eof flags a sticky overrun
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_idx   <= '0;
            overrun  <= 1'b0;
            eof_seen <= 1'b0;
        end else if (take) begin
            eof_seen <= pix_eof;
            if (emit) begin
                wd_idx <= next_idx;
                if (wrap && !pix_eof)
                    overrun <= 1'b1;
            end else if (restart) begin
                wd_idx <= '0;
            end
        end
    end

    // Frame FSM plus completion pulse and counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_done <= eof_hs;
            if (eof_hs)
                frame_count <= frame_count + 8'd1;
            if (restart)
                state <= ST_ACTIVE;
            else if (eof_hs)
                state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Randomized and directed bench for sram_pixel_writer with a frame-level
// reference model. Honors SRAM_WRITER_DOUBLE_BUFFER_EN when defined.
module tb_sram_pixel_writer;

    localparam int AW = 19;
    localparam int FB = 8;
    localparam int FW = 4;
    localparam int WW = 36 + AW;
`ifdef SRAM_WRITER_DOUBLE_BUFFER_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [7:0]    pix_data = 8'h00;
    logic          pix_sof = 1'b0;
    logic          pix_eof = 1'b0;
    logic          w_din_valid;
    logic          w_din_ready = 1'b1;
    logic [WW-1:0] w_din;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          overrun;
    logic          buf_sel;

    always #5 clock = ~clock;

    sram_pixel_writer #(
        .ADDR_WIDTH  (AW),
        .FRAME_BASE  (FB),
        .FRAME_WORDS (FW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eof     (pix_eof),
        .w_din_valid (w_din_valid),
        .w_din_ready (w_din_ready),
        .w_din       (w_din),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overrun     (overrun),
        .buf_sel     (buf_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] mkw(input logic [3:0] m, input int a, input logic [31:0] d);
        return {m, AW'(a), d};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          eof;
        logic [WW-1:0] word;
    } exp_t;

    exp_t          exp_q[$];
    logic [WW-1:0] hs_log[$];
    logic          m_open;
    int            m_n;
    logic [31:0]   m_data;
    int            m_idx;
    int            m_frames;
    logic          m_buf;
    logic          exp_done;
    logic [7:0]    exp_fc;
    logic          exp_ovr;
    logic          exp_bs;
    int            done_cnt = 0;
    logic          prev_stall;
    logic [WW-1:0] prev_word;
    int            ready_mode = 0;

    task automatic model_reset();
        exp_q.delete();
        hs_log.delete();
        m_open   = 1'b0;
        m_n      = 0;
        m_data   = 32'h0;
        m_idx    = 0;
        m_frames = 0;
        m_buf    = 1'b0;
        exp_done = 1'b0;
        exp_fc   = 8'd0;
        exp_ovr  = 1'b0;
        exp_bs   = 1'b0;
    endtask

    // Frame rules applied to one accepted pixel
    task automatic model_pixel(input logic [7:0] d, input logic s, input logic e);
        int   a;
        exp_t ew;
        if (s) begin
            m_open = 1'b1;
            m_n    = 0;
            m_data = 32'h0;
            m_idx  = 0;
            m_buf  = DB_EN && (m_frames % 2 == 1);
        end
        if (!m_open)
            return;
        m_data[8*m_n +: 8] = d;
        m_n++;
        if (m_n == 4 || e) begin
            a = FB + (m_buf ? FW : 0) + m_idx;
            ew.eof  = e;
            ew.word = mkw(4'((1 << m_n) - 1), a, m_data);
            exp_q.push_back(ew);
            m_idx++;
            if (m_idx == FW) begin
                m_idx = 0;
                if (!e)
                    exp_ovr = 1'b1;
            end
            m_n    = 0;
            m_data = 32'h0;
            if (e) begin
                m_open = 1'b0;
                m_frames++;
            end
        end
    endtask

    // Monitor: sample half a cycle away from the active edge
    always @(negedge clock) begin
        exp_t ew;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            check_eq("pix_ready", pix_ready, !w_din_valid || w_din_ready);
            if (prev_stall) begin
                check_eq("hold_valid", w_din_valid, 1'b1);
                check_eq("hold_word", w_din, prev_word);
            end
            check_eq("frame_done", frame_done, exp_done);
            check_eq("frame_count", frame_count, exp_fc);
            check_eq("overrun", overrun, exp_ovr);
            check_eq("buf_sel", buf_sel, exp_bs);
            if (frame_done)
                done_cnt++;
            exp_done = 1'b0;
            if (w_din_valid && w_din_ready) begin
                hs_log.push_back(w_din);
                check_eq("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    ew = exp_q.pop_front();
                    check_eq("w_din", w_din, ew.word);
                    if (ew.eof) begin
                        exp_done = 1'b1;
                        exp_fc   = exp_fc + 8'd1;
                        if (DB_EN)
                            exp_bs = ~exp_bs;
                    end
                end
            end
            if (pix_valid && pix_ready)
                model_pixel(pix_data, pix_sof, pix_eof);
            prev_stall = w_din_valid && !w_din_ready;
            prev_word  = w_din;
        end
    end

    // Arbiter ready generator
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       w_din_ready = 1'b1;
            1:       w_din_ready = 1'($urandom_range(0, 1));
            default: w_din_ready = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clock);
        #2;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
        reset     = 1'b1;
        model_reset();
        #1;
        check_eq("rst_w_din_valid", w_din_valid, 1'b0);
        check_eq("rst_w_din", w_din, '0);
        check_eq("rst_pix_ready", pix_ready, 1'b1);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_frame_count", frame_count, 8'd0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_buf_sel", buf_sel, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic s, input logic e);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        pix_eof   = e;
        while (!acc && t < 200) begin
            @(negedge clock);
            acc = pix_ready;
            @(posedge clock);
            #1;
            t++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
        check_eq("pix_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        ready_mode = 0;
        while ((exp_q.size() != 0 || w_din_valid) && t < 200) begin
            @(posedge clock);
            t++;
        end
        repeat (2) @(posedge clock);
        #1;
        check_eq("drain_timeout", t >= 200, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        model_reset();

        // Two full words, eof on the 8th pixel
        do_reset();
        d0 = done_cnt;
        for (int i = 1; i <= 8; i++)
            send_pix(8'(i), i == 1, i == 8);
        drain();
        check_eq("t35_nwords", hs_log.size(), 2);
        check_eq("t35_word0", hs_log[0], mkw(4'hF, FB, 32'h04030201));
        check_eq("t35_word1", hs_log[1], mkw(4'hF, FB + 1, 32'h08070605));
        check_eq("t35_ndone", done_cnt - d0, 1);
        check_eq("t35_fcount", frame_count, 8'd1);

        // Partial last word
        do_reset();
        for (int i = 1; i <= 6; i++)
            send_pix(8'(i), i == 1, i == 6);
        drain();
        check_eq("t36_nwords", hs_log.size(), 2);
        check_eq("t36_word1", hs_log[1], mkw(4'b0011, FB + 1, 32'h00000605));

        // Backpressure for 5 cycles with a pixel waiting
        do_reset();
        ready_mode = 2;
        for (int i = 1; i <= 4; i++)
            send_pix(8'(i), i == 1, 1'b0);
        pix_valid = 1'b1;
        pix_data  = 8'h05;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("t37_pix_ready", pix_ready, 1'b0);
            check_eq("t37_valid", w_din_valid, 1'b1);
        end
        ready_mode = 0;
        @(posedge clock);
        #1;
        for (int i = 5; i <= 8; i++)
            send_pix(8'(i), 1'b0, i == 8);
        drain();
        check_eq("t37_nwords", hs_log.size(), 2);
        check_eq("t37_word0", hs_log[0], mkw(4'hF, FB, 32'h04030201));
        check_eq("t37_word1", hs_log[1], mkw(4'hF, FB + 1, 32'h08070605));

        // Overrun: five words without eof
        do_reset();
        for (int i = 0; i < 20; i++)
            send_pix(8'(i + 16), i == 0, 1'b0);
        drain();
        check_eq("t38_nwords", hs_log.size(), 5);
        for (int k = 0; k < 5 && k < hs_log.size(); k++)
            check_eq("t38_addr", hs_log[k][32 +: AW], AW'(FB + (k % FW)));
        check_eq("t38_overrun", overrun, 1'b1);

        // Two short frames: buffer placement
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 1; i <= 4; i++)
                send_pix(8'(i + 4 * f), i == 1, i == 4);
        drain();
        check_eq("t39_nwords", hs_log.size(), 2);
        check_eq("t39_addr0", hs_log[0][32 +: AW], AW'(FB));
        check_eq("t39_addr1", hs_log[1][32 +: AW], AW'(FB + (DB_EN ? FW : 0)));
        check_eq("t39_buf_sel", buf_sel, 1'b0);
        check_eq("t39_fcount", frame_count, 8'd2);

        // Reset with a word in flight
        do_reset();
        ready_mode = 2;
        for (int i = 1; i <= 4; i++)
            send_pix(8'(i), i == 1, 1'b0);
        check_eq("t40_pending", w_din_valid, 1'b1);
        do_reset();
        ready_mode = 0;
        for (int i = 1; i <= 4; i++)
            send_pix(8'(i + 32), i == 1, i == 4);
        drain();
        check_eq("t40_nwords", hs_log.size(), 1);
        check_eq("t40_word0", hs_log[0], mkw(4'hF, FB, 32'h24232221));

        // Idle pixels dropped, then sof+eof single-pixel frame
        do_reset();
        for (int i = 0; i < 3; i++)
            send_pix(8'hEE, 1'b0, 1'b0);
        send_pix(8'hAB, 1'b1, 1'b1);
        drain();
        check_eq("sofeof_nwords", hs_log.size(), 1);
        check_eq("sofeof_word", hs_log[0], mkw(4'b0001, FB, 32'h000000AB));
        check_eq("sofeof_fcount", frame_count, 8'd1);

        // sof in mid-frame: queued word kept, partial dropped, address restarts
        do_reset();
        for (int i = 1; i <= 5; i++)
            send_pix(8'(i), i == 1, 1'b0);
        for (int i = 9; i <= 12; i++)
            send_pix(8'(i), i == 9, i == 12);
        drain();
        check_eq("resof_nwords", hs_log.size(), 2);
        check_eq("resof_word0", hs_log[0], mkw(4'hF, FB, 32'h04030201));
        check_eq("resof_word1", hs_log[1], mkw(4'hF, FB, 32'h0C0B0A09));
        check_eq("resof_fcount", frame_count, 8'd1);

        // Random traffic against the model
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clock);
                #1;
            end
            send_pix(8'($urandom_range(0, 255)),
                     (i == 0) || ($urandom_range(0, 19) == 0),
                     $urandom_range(0, 9) == 0);
        end
        drain();
        check_eq("rand_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
